// File: rtl/tag_pkg.sv
// Shared types and constants for the tag check scheduler.
// Holds the key width, key reset value, FSM states and rotate helper.
package tag_pkg;

  localparam int KEY_W = 16;
  localparam logic [KEY_W-1:0] KEY_RESET = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESP
  } state_t;

  // bsz is a power of two, so the modulo reduces to a mask
  function automatic logic [2:0] rot_amt(
    input logic [KEY_W-1:0] key,
    input int               blk,
    input int               bsz
  );
    logic [2:0] r;
    r = key[3*blk +: 3];
    return r & 3'(bsz - 1);
  endfunction

endpackage

// File: rtl/tag_compute.sv
// Combinational memory-tag function: flip, rotate and XOR four blocks.
// Shared by all requesters through the scheduler's latched operands.
module tag_compute
  import tag_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int BLOCK_SIZE = DATA_SIZE/4
)(
  input  logic [DATA_SIZE-1:0]  i_data,
  input  logic [KEY_W-1:0]      i_key,
  output logic [BLOCK_SIZE-1:0] o_tag
);

  logic [BLOCK_SIZE-1:0]   w_blk;
  logic [2*BLOCK_SIZE-1:0] w_dbl;

  always_comb begin
    o_tag = '0;
    w_blk = '0;
    w_dbl = '0;
    for (int i = 0; i < 4; i++) begin
      w_blk = i_data[i*BLOCK_SIZE +: BLOCK_SIZE]
            ^ {BLOCK_SIZE{i_key[i]}};
      w_dbl = {w_blk, w_blk} << rot_amt(i_key, i, BLOCK_SIZE);
      o_tag = o_tag ^ w_dbl[2*BLOCK_SIZE-1 -: BLOCK_SIZE];
    end
  end

endmodule

// File: rtl/tag_check_scheduler.sv
// Round-robin scheduler sharing one tag unit; owns the secret key.
// Optional mismatch counter: define TAG_MISMATCH_COUNT_EN.
module tag_check_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_SIZE  = 32,
  parameter int BLOCK_SIZE = DATA_SIZE/4,
  parameter logic [tag_pkg::KEY_W-1:0] KEY_RESET =
    tag_pkg::KEY_RESET
)(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_SIZE-1:0]  req_data,
  input  logic [NUM_REQ*BLOCK_SIZE-1:0] req_tag,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id,
  output logic [BLOCK_SIZE-1:0]         resp_tag,
  output logic                          resp_match,
  input  logic                          cfg_key_valid,
  input  logic [15:0]                   cfg_key,
  output logic                          cfg_key_ready
`ifdef TAG_MISMATCH_COUNT_EN
  ,
  input  logic                          mismatch_clr,
  output logic [15:0]                   mismatch_cnt
`endif
);

  import tag_pkg::*;

  localparam int IDW = $clog2(NUM_REQ);

  state_t                r_state;
  state_t                w_next;
  logic [KEY_W-1:0]      r_key;
  logic [KEY_W-1:0]      r_opkey;
  logic [IDW-1:0]        r_last;
  logic [IDW-1:0]        r_id;
  logic [IDW-1:0]        w_win;
  logic [IDW-1:0]        w_sel;
  logic [DATA_SIZE-1:0]  r_data;
  logic [BLOCK_SIZE-1:0] r_exp;
  logic [BLOCK_SIZE-1:0] r_tag;
  logic [BLOCK_SIZE-1:0] w_tag;
  logic                  r_match;
  logic                  w_any;
  logic                  w_grant;
  logic                  w_key_wr;

  // descending scan so the smallest offset past r_last wins
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_sel = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_sel = IDW'((int'(r_last) + k) % NUM_REQ);
      if (req_valid[w_sel]) begin
        w_any = 1'b1;
        w_win = w_sel;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    req_ready     = '0;
    cfg_key_ready = 1'b0;
    w_grant       = 1'b0;
    w_key_wr      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cfg_key_valid) begin
          cfg_key_ready = 1'b1;
          w_key_wr      = 1'b1;
        end else if (w_any) begin
          w_grant          = 1'b1;
          req_ready[w_win] = 1'b1;
          w_next           = COMPUTE;
        end
      end
      COMPUTE: w_next = RESP;
      RESP: begin
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_key   <= KEY_RESET;
      r_opkey <= KEY_RESET;
      r_last  <= IDW'(NUM_REQ - 1);
      r_id    <= '0;
      r_data  <= '0;
      r_exp   <= '0;
      r_tag   <= '0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_key_wr) r_key <= cfg_key;
      if (w_grant) begin
        r_last  <= w_win;
        r_id    <= w_win;
        r_opkey <= r_key;
        r_data  <= req_data[w_win*DATA_SIZE +: DATA_SIZE];
        r_exp   <= req_tag[w_win*BLOCK_SIZE +: BLOCK_SIZE];
      end
      if (r_state == COMPUTE) begin
        r_tag   <= w_tag;
        r_match <= (w_tag == r_exp);
      end
    end
  end

  tag_compute #(
    .DATA_SIZE  (DATA_SIZE),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_tag (
    .i_data (r_data),
    .i_key  (r_opkey),
    .o_tag  (w_tag)
  );

  assign resp_valid = (r_state == RESP);
  assign resp_id    = r_id;
  assign resp_tag   = r_tag;
  assign resp_match = r_match;

`ifdef TAG_MISMATCH_COUNT_EN
  logic [15:0] r_mcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcnt <= '0;
    end else if (mismatch_clr) begin
      r_mcnt <= '0;
    end else if (resp_valid && resp_ready && !r_match
                 && r_mcnt != 16'hFFFF) begin
      r_mcnt <= r_mcnt + 16'd1;
    end
  end

  assign mismatch_cnt = r_mcnt;
`endif

endmodule
